// File: rtl/cmem_fill_pkg.sv
// Shared constants and state type for the cmem line-fill engine.
package cmem_fill_pkg;

    localparam int unsigned CMEM_LINE    = 512;
    localparam int unsigned CMEM_BLK_LEN = 58;
    localparam int unsigned CMEM_BEAT_W  = 64;
    localparam int unsigned MEM_ADDR_W   = 64;

    typedef enum logic [1:0] {
        FILL_S_IDLE = 2'd0,
        FILL_S_REQ  = 2'd1,
        FILL_S_RECV = 2'd2,
        FILL_S_DONE = 2'd3
    } fill_state_e;

endpackage

// File: rtl/cmem_fill_if.sv
// Memory-side burst port of the line-fill engine: request/grant plus beat return.
interface cmem_fill_if
    import cmem_fill_pkg::*;
#(
    parameter int unsigned BEAT_W = CMEM_BEAT_W
);
    logic [MEM_ADDR_W-1:0] m_addr;
    logic                  m_req;
    logic                  m_gnt;
    logic [BEAT_W-1:0]     m_rdata;
    logic                  m_rvalid;

    modport master (
        output m_addr,
        output m_req,
        input  m_gnt,
        input  m_rdata,
        input  m_rvalid
    );

    modport slave (
        input  m_addr,
        input  m_req,
        output m_gnt,
        output m_rdata,
        output m_rvalid
    );
endinterface

// File: rtl/cmem_fill.sv
// Line-fill engine: one burst per cmem miss, beats assembled into a full line,
// delivered with a single-cycle valid pulse.
module cmem_fill
    import cmem_fill_pkg::*;
#(
    parameter int unsigned LINE_W = CMEM_LINE,
    parameter int unsigned BLK_W  = CMEM_BLK_LEN,
    parameter int unsigned BEAT_W = CMEM_BEAT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BLK_W-1:0]  b_addr_c,
    input  logic              b_rd_c,
    output logic [LINE_W-1:0] b_rdata_c,
    output logic              b_dv_c,
    cmem_fill_if.master       mem
);

    localparam int unsigned BEATS = LINE_W / BEAT_W;
    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam int unsigned OFF_W = MEM_ADDR_W - BLK_W;

    fill_state_e       state_q, state_d;
    logic [BLK_W-1:0]  addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [LINE_W-1:0] line_q;
    logic              abort_q;
    logic              req_q, req_d;
    logic              dv_q, dv_d;
    logic              capture_c, grant_c, beat_c, last_beat_c, abort_set_c;

    // Beat decode shared by the next-state and datapath logic.
    assign grant_c     = (state_q == FILL_S_REQ)  && mem.m_gnt;
    assign beat_c      = (state_q == FILL_S_RECV) && mem.m_rvalid;
    assign last_beat_c = beat_c && (cnt_q == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FILL_S_IDLE;
        else        state_q <= state_d;
    end

    // A grant that coincides with withdrawal still commits the burst; it is drained as an abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL_S_IDLE: if (b_rd_c) state_d = FILL_S_REQ;
            FILL_S_REQ: begin
                if (mem.m_gnt)   state_d = FILL_S_RECV;
                else if (!b_rd_c) state_d = FILL_S_IDLE;
            end
            FILL_S_RECV: begin
                if (last_beat_c) state_d = (abort_q || !b_rd_c) ? FILL_S_IDLE : FILL_S_DONE;
            end
            FILL_S_DONE: state_d = FILL_S_IDLE;
            default:     state_d = FILL_S_IDLE;
        endcase
    end

    always_comb begin
        req_d       = (state_d == FILL_S_REQ);
        dv_d        = (state_d == FILL_S_DONE);
        capture_c   = 1'b0;
        abort_set_c = 1'b0;
        case (state_q)
            FILL_S_IDLE: capture_c   = b_rd_c;
            FILL_S_REQ:  abort_set_c = mem.m_gnt && !b_rd_c;
            FILL_S_RECV: abort_set_c = !b_rd_c;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            req_q   <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            req_q <= req_d;
            dv_q  <= dv_d;
            if (capture_c) begin
                addr_q  <= b_addr_c;
                abort_q <= 1'b0;
            end else if (abort_set_c) begin
                abort_q <= 1'b1;
            end
            if (grant_c)     cnt_q <= '0;
            else if (beat_c) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Beat n lands in the n-th lowest slice; the buffer is otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else begin
            for (int unsigned i = 0; i < BEATS; i++) begin
                if (beat_c && (cnt_q == CNT_W'(i))) line_q[i*BEAT_W +: BEAT_W] <= mem.m_rdata;
            end
        end
    end

    assign mem.m_addr = {addr_q, {OFF_W{1'b0}}};
    assign mem.m_req  = req_q;
    assign b_dv_c     = dv_q;
    assign b_rdata_c  = line_q;

endmodule
